// File: rtl/pc_next_unit_if.sv
// Bus between the instruction-control logic and pc_next_unit.
// The master drives the decoded control and operand values; the slave is
// the next-PC unit, returning the PC, link value, statistics and trap state.
interface pc_next_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             stall;
  logic             branch;
  logic             jump;
  logic             jalr;
  logic [2:0]       funct3;
  logic [XLEN-1:0]  rs1_val;
  logic [XLEN-1:0]  rs2_val;
  logic [XLEN-1:0]  imm;
  logic             trap_ack;

  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  pc_plus4;
  logic             taken;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] taken_count;
  logic             trap_pending;
  logic [XLEN-1:0]  trap_addr;

  modport master (
    output stall, branch, jump, jalr, funct3, rs1_val, rs2_val, imm, trap_ack,
    input  pc, pc_plus4, taken, branch_count, taken_count, trap_pending, trap_addr
  );

  modport slave (
    input  stall, branch, jump, jalr, funct3, rs1_val, rs2_val, imm, trap_ack,
    output pc, pc_plus4, taken, branch_count, taken_count, trap_pending, trap_addr
  );
endinterface

// File: rtl/pc_next_unit.sv
// Registered program counter with next-PC selection for the single-cycle
// datapath: resolves the six conditional branches, JAL and JALR, holds under
// stall and keeps saturating branch statistics.
// Optional feature macro MISALIGN_TRAP_EN: when defined, a control transfer
// to a target with bits [1:0] != 0 parks the unit in a TRAP state until
// trap_ack, then restarts at TRAP_VECTOR. When undefined, targets are
// word-aligned by clearing bits [1:0] and the trap outputs read as zero.
module pc_next_unit #(
  parameter int                XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0]   TRAP_VECTOR  = 32'h0000_0100,
  parameter int                CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  pc_next_unit_if.slave    bus
);

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  logic signed [XLEN-1:0] rs1_s;
  logic signed [XLEN-1:0] rs2_s;
  logic                   cond;
  logic                   taken;
  logic [XLEN-1:0]        pc_plus4;
  logic [XLEN-1:0]        jalr_sum;
  logic [XLEN-1:0]        target;
  logic                   br_taken_only;

  assign rs1_s         = bus.rs1_val;
  assign rs2_s         = bus.rs2_val;
  assign pc_plus4      = pc_q + XLEN'(4);
  assign jalr_sum      = bus.rs1_val + bus.imm;
  assign target        = bus.jalr ? {jalr_sum[XLEN-1:1], 1'b0} : pc_q + bus.imm;
  assign taken         = bus.jalr | bus.jump | (bus.branch & cond);
  // taken_count only credits a branch that actually steered the PC itself
  assign br_taken_only = bus.branch & cond & ~bus.jump & ~bus.jalr;

  // Branch condition decode; funct3 010/011 are reserved and never taken
  always_comb begin
    cond = 1'b0;
    case (bus.funct3)
      3'b000:  cond = (bus.rs1_val == bus.rs2_val);
      3'b001:  cond = (bus.rs1_val != bus.rs2_val);
      3'b100:  cond = (rs1_s <  rs2_s);
      3'b101:  cond = (rs1_s >= rs2_s);
      3'b110:  cond = (bus.rs1_val <  bus.rs2_val);
      3'b111:  cond = (bus.rs1_val >= bus.rs2_val);
      default: cond = 1'b0;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  typedef enum logic {ST_RUN = 1'b0, ST_TRAP = 1'b1} state_e;

  state_e          state_q, state_d;
  logic            trap_pending_q, trap_pending_d;
  logic [XLEN-1:0] trap_addr_q, trap_addr_d;
  logic            misalign;

  assign misalign = taken & (target[1:0] != 2'b00);

  // Next-state: RUN advances the PC unless the transfer is misaligned;
  // TRAP ignores stall and waits only for the acknowledge
  always_comb begin
    pc_d           = pc_q;
    branch_cnt_d   = branch_cnt_q;
    taken_cnt_d    = taken_cnt_q;
    state_d        = state_q;
    trap_pending_d = trap_pending_q;
    trap_addr_d    = trap_addr_q;
    case (state_q)
      ST_RUN: begin
        if (!bus.stall) begin
          if (bus.branch)    branch_cnt_d = sat_inc(branch_cnt_q);
          if (br_taken_only) taken_cnt_d  = sat_inc(taken_cnt_q);
          if (misalign) begin
            state_d        = ST_TRAP;
            trap_pending_d = 1'b1;
            trap_addr_d    = target;
          end else begin
            pc_d = taken ? target : pc_plus4;
          end
        end
      end
      ST_TRAP: begin
        if (bus.trap_ack) begin
          state_d        = ST_RUN;
          trap_pending_d = 1'b0;
          pc_d           = TRAP_VECTOR;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State registers, asynchronously returned to RUN at RESET_VECTOR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q           <= RESET_VECTOR;
      branch_cnt_q   <= '0;
      taken_cnt_q    <= '0;
      state_q        <= ST_RUN;
      trap_pending_q <= 1'b0;
      trap_addr_q    <= '0;
    end else begin
      pc_q           <= pc_d;
      branch_cnt_q   <= branch_cnt_d;
      taken_cnt_q    <= taken_cnt_d;
      state_q        <= state_d;
      trap_pending_q <= trap_pending_d;
      trap_addr_q    <= trap_addr_d;
    end
  end

  assign bus.trap_pending = trap_pending_q;
  assign bus.trap_addr    = trap_addr_q;
`else
  logic unused_ok;

  // Without trapping, the low target bits are dropped so the PC stays word-aligned
  always_comb begin
    pc_d         = pc_q;
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    if (!bus.stall) begin
      if (bus.branch)    branch_cnt_d = sat_inc(branch_cnt_q);
      if (br_taken_only) taken_cnt_d  = sat_inc(taken_cnt_q);
      pc_d = taken ? {target[XLEN-1:2], 2'b00} : pc_plus4;
    end
  end

  // PC and statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_VECTOR;
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      pc_q         <= pc_d;
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign bus.trap_pending = 1'b0;
  assign bus.trap_addr    = '0;
  assign unused_ok        = ^{bus.trap_ack, TRAP_VECTOR, target[1:0]};
`endif

  assign bus.pc           = pc_q;
  assign bus.pc_plus4     = pc_plus4;
  assign bus.taken        = taken;
  assign bus.branch_count = branch_cnt_q;
  assign bus.taken_count  = taken_cnt_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Bench for pc_next_unit: directed scenarios followed by random control
// traffic, all compared against a behavioural model of the PC rules.
// A second instance with 3-bit counters shares the same stimulus.
// Follows MISALIGN_TRAP_EN in the same way as the design.
module tb_pc_next_unit;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR  = 32'h0000_0100;
  localparam longint unsigned MOD      = 64'h1_0000_0000;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pc_next_unit_if #(.XLEN(32), .CNT_W(16)) bus ();
  pc_next_unit_if #(.XLEN(32), .CNT_W(3))  bus_s ();

  assign bus_s.stall    = bus.stall;
  assign bus_s.branch   = bus.branch;
  assign bus_s.jump     = bus.jump;
  assign bus_s.jalr     = bus.jalr;
  assign bus_s.funct3   = bus.funct3;
  assign bus_s.rs1_val  = bus.rs1_val;
  assign bus_s.rs2_val  = bus.rs2_val;
  assign bus_s.imm      = bus.imm;
  assign bus_s.trap_ack = bus.trap_ack;

  pc_next_unit #(.XLEN(32), .RESET_VECTOR(RESET_VECTOR), .TRAP_VECTOR(TRAP_VECTOR), .CNT_W(16))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  pc_next_unit #(.XLEN(32), .RESET_VECTOR(RESET_VECTOR), .TRAP_VECTOR(TRAP_VECTOR), .CNT_W(3))
    dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state
  longint unsigned m_pc;
  longint unsigned m_taddr;
  int unsigned     m_bc, m_tc, m_bc3, m_tc3;
  bit              m_trap;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_cond(input bit [2:0] f, input bit [31:0] a, input bit [31:0] b);
    longint sa, sb;
    sa = (a >= 32'h8000_0000) ? longint'(a) - longint'(MOD) : longint'(a);
    sb = (b >= 32'h8000_0000) ? longint'(b) - longint'(MOD) : longint'(b);
    case (f)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return sa < sb;
      3'd5:    return sa >= sb;
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int unsigned sat(input int unsigned v, input int w);
    return (v < (2 ** w) - 1) ? v + 1 : v;
  endfunction

  task automatic drive(input bit st, input bit br, input bit j, input bit jr, input bit [2:0] f,
                       input bit [31:0] a, input bit [31:0] b, input bit [31:0] im, input bit ack);
    bus.stall = st; bus.branch = br; bus.jump = j; bus.jalr = jr; bus.funct3 = f;
    bus.rs1_val = a; bus.rs2_val = b; bus.imm = im; bus.trap_ack = ack;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "/pc"},    bus.pc, m_pc);
    chk({tag, "/bc"},    bus.branch_count, m_bc);
    chk({tag, "/tc"},    bus.taken_count, m_tc);
    chk({tag, "/trp"},   bus.trap_pending, m_trap);
    chk({tag, "/taddr"}, bus.trap_addr, m_taddr);
    chk({tag, "/pc_s"},  bus_s.pc, m_pc);
    chk({tag, "/bc3"},   bus_s.branch_count, m_bc3);
    chk({tag, "/tc3"},   bus_s.taken_count, m_tc3);
  endtask

  // One clock: check combinational outputs, advance model on the edge, check registers
  task automatic tick(input string tag);
    bit c, tk;
    longint unsigned tgt;
    #1;
    c  = m_cond(bus.funct3, bus.rs1_val, bus.rs2_val);
    tk = bus.jalr || bus.jump || (bus.branch && c);
    if (bus.jalr) begin
      tgt = (longint'(bus.rs1_val) + longint'(bus.imm)) % MOD;
      tgt = tgt - (tgt % 2);
    end else begin
      tgt = (m_pc + longint'(bus.imm)) % MOD;
    end
    chk({tag, "/taken"}, bus.taken, tk);
    chk({tag, "/pc4"},   bus.pc_plus4, (m_pc + 4) % MOD);
    @(posedge clk);
    if (m_trap) begin
      if (bus.trap_ack) begin
        m_trap = 1'b0;
        m_pc   = TRAP_VECTOR;
      end
    end else if (!bus.stall) begin
      if (bus.branch) begin
        m_bc  = sat(m_bc, 16);
        m_bc3 = sat(m_bc3, 3);
      end
      if (bus.branch && c && !bus.jump && !bus.jalr) begin
        m_tc  = sat(m_tc, 16);
        m_tc3 = sat(m_tc3, 3);
      end
      if (tk && TRAP_EN && (tgt % 4 != 0)) begin
        m_trap  = 1'b1;
        m_taddr = tgt;
      end else if (tk) begin
        m_pc = TRAP_EN ? tgt : tgt - (tgt % 4);
      end else begin
        m_pc = (m_pc + 4) % MOD;
      end
    end
    #1;
    check_regs(tag);
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any clock edge
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    m_pc = RESET_VECTOR; m_taddr = 0; m_trap = 1'b0;
    m_bc = 0; m_tc = 0; m_bc3 = 0; m_tc3 = 0;
    check_regs(tag);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
    m_pc = 0; m_taddr = 0; m_trap = 0; m_bc = 0; m_tc = 0; m_bc3 = 0; m_tc3 = 0;
    #12;
    check_regs("reset");
    chk("reset_pc_const", bus.pc, RESET_VECTOR);
    @(negedge clk);
    rst_n = 1'b1;

    // Free-running sequential fetch up to 0x10
    tick("seq0"); chk("seq_pc4", bus.pc, 32'h4);
    tick("seq1"); chk("seq_pc8", bus.pc, 32'h8);
    tick("seq2");
    tick("seq3"); chk("seq_pc10", bus.pc, 32'h10);

    // BEQ taken, then BNE with the same operands falls through
    drive(0, 1, 0, 0, 3'b000, 5, 5, 16, 0); tick("beq");
    chk("beq_pc", bus.pc, 32'h20);
    drive(0, 1, 0, 0, 3'b001, 5, 5, 16, 0); tick("bne");
    chk("bne_pc", bus.pc, 32'h24);
    chk("bne_bc", bus.branch_count, 2);
    chk("bne_tc", bus.taken_count, 1);

    // Signed versus unsigned compare of -1 against 1
    drive(0, 1, 0, 0, 3'b100, 32'hFFFF_FFFF, 1, 8, 0); tick("blt");
    chk("blt_pc", bus.pc, 32'h2C);
    drive(0, 1, 0, 0, 3'b110, 32'hFFFF_FFFF, 1, 8, 0); tick("bltu");
    chk("bltu_pc", bus.pc, 32'h30);
    drive(0, 1, 0, 0, 3'b010, 32'hFFFF_FFFF, 1, 8, 0); tick("f010");
    drive(0, 1, 0, 0, 3'b011, 7, 7, 8, 0); tick("f011");

    // JALR landing on a half-word boundary, then an aligned JALR
    drive(0, 0, 0, 1, 3'b000, 32'h1001, 0, 2, 0); tick("jalr_hw");
    drive(0, 0, 0, 0, 3'b000, 0, 0, 0, 1); tick("jalr_ack");
    drive(0, 0, 0, 1, 3'b000, 32'h1001, 0, 7, 0); tick("jalr");
    chk("jalr_pc", bus.pc, 32'h1008);

    // Stall with a taken branch held for three edges
    drive(1, 1, 0, 0, 3'b000, 3, 3, 64, 0);
    tick("stall0"); tick("stall1"); tick("stall2");
    chk("stall_pc", bus.pc, 32'h1008);

    // JAL to a misaligned target from 0x40
    drive(0, 0, 0, 1, 3'b000, 32'h40, 0, 0, 0); tick("to40");
    drive(0, 0, 1, 0, 3'b000, 0, 0, 6, 0); tick("jal_mis");
    chk("jal_mis_pc", bus.pc, TRAP_EN ? 32'h40 : 32'h44);
    chk("jal_mis_trp", bus.trap_pending, TRAP_EN);
    chk("jal_mis_addr", bus.trap_addr, TRAP_EN ? 32'h46 : 32'h0);
    drive(1, 1, 0, 0, 3'b000, 1, 1, 8, 0); tick("trap_wait0");
    drive(0, 0, 1, 0, 3'b000, 0, 0, 8, 0); tick("trap_wait1");
    drive(0, 0, 0, 0, 3'b000, 0, 0, 0, 1); tick("trap_ack");
    drive(0, 0, 0, 0, 3'b000, 0, 0, 0, 0); tick("after_ack");

    // Reset asserted while a trap may be pending
    drive(0, 1, 0, 0, 3'b000, 9, 9, 2, 0); tick("trap_again");
    drive(0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    do_reset("mid_reset");
    tick("post_reset");
    chk("post_reset_pc", bus.pc, RESET_VECTOR + 4);

    // Ten taken BEQs saturate the 3-bit counters
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 0, 0, 3'b000, i, i, 4, 0);
      tick("sat");
    end
    chk("sat_bc3", bus_s.branch_count, 7);
    chk("sat_tc3", bus_s.taken_count, 7);
    chk("sat_bc16", bus.branch_count, 10);

    // Random control traffic
    for (int i = 0; i < 400; i++) begin
      bit [31:0] a, b, im;
      a  = $urandom;
      b  = ($urandom_range(0, 2) == 0) ? a : $urandom;
      im = ($urandom_range(0, 7) == 0) ? $urandom : (($urandom_range(0, 255) - 128) * 4);
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)), a, b, im,
            $urandom_range(0, 2) == 0);
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
